// File: rtl/cnn_pkg.sv
// Shared CNN datapath definitions: MAC sequencer state encoding, default widths,
// and the output saturation helper reused by the pooling blocks.
package cnn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } mac_state_t;

    localparam int CNN_DATA_W = 8;
    localparam int CNN_OUT_W  = 16;

    // Saturation works on a sign-extended 32-bit view of any accumulator up to 32 bits.
    localparam int SAT_IN_W = 32;
    localparam logic signed [SAT_IN_W-1:0] SAT_MAX = (SAT_IN_W'(1) <<< (CNN_OUT_W - 1)) - SAT_IN_W'(1);
    localparam logic signed [SAT_IN_W-1:0] SAT_MIN = -(SAT_IN_W'(1) <<< (CNN_OUT_W - 1));

    function automatic logic [CNN_OUT_W-1:0] sat_out(input logic signed [SAT_IN_W-1:0] v);
        logic [CNN_OUT_W-1:0] r;
        if (v > SAT_MAX) begin
            r = SAT_MAX[CNN_OUT_W-1:0];
        end else if (v < SAT_MIN) begin
            r = SAT_MIN[CNN_OUT_W-1:0];
        end else begin
            r = v[CNN_OUT_W-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/signedm.sv
// Single shared signed multiplier: full-precision 2*DATA_W product of two
// two's-complement operands.
module signedm #(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0]   i_a,
    input  logic [DATA_W-1:0]   i_b,
    output logic [2*DATA_W-1:0] o_p
);

    assign o_p = $signed(i_a) * $signed(i_b);

endmodule

// File: rtl/mac_seq.sv
// Dot-product sequencer around one shared signed multiplier. Optional output
// saturation is enabled by defining MAC_SAT_EN; otherwise the result wraps.
module mac_seq
    import cnn_pkg::*;
#(
    parameter int DATA_W = CNN_DATA_W,
    parameter int LEN_W  = 8,
    parameter int ACC_W  = 24,
    parameter int OUT_W  = CNN_OUT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    input  logic [DATA_W-1:0] a_in,
    input  logic [DATA_W-1:0] b_in,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [OUT_W-1:0]  res_out,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [1:0]        dbg_state
);

    // Handshakes: a pair moves on any edge where in_valid & in_ready; the result
    // is consumed on any edge where res_valid & res_ready. Neither valid waits on ready.

    localparam int PROD_W = 2 * DATA_W;

    mac_state_t          r_state;
    mac_state_t          w_next;
    logic [LEN_W-1:0]    r_len;
    logic [LEN_W-1:0]    r_cnt;
    logic [LEN_W-1:0]    w_cnt_inc;
    logic [PROD_W-1:0]   r_pq;
    logic                r_pv;
    logic [ACC_W-1:0]    r_acc;
    logic [PROD_W-1:0]   w_prod;
    logic                w_xfer;
    logic                w_last;

    signedm #(.DATA_W(DATA_W)) u_mul (
        .i_a (a_in),
        .i_b (b_in),
        .o_p (w_prod)
    );

    assign in_ready  = (r_state == ST_RUN) && (r_cnt < r_len);
    assign w_xfer    = in_valid && in_ready;
    assign w_cnt_inc = r_cnt + LEN_W'(1);
    assign w_last    = w_xfer && (w_cnt_inc == r_len);
    assign busy      = (r_state != ST_IDLE);
    assign res_valid = (r_state == ST_DONE);
    assign dbg_state = r_state;

`ifdef MAC_SAT_EN
    assign res_out = OUT_W'(sat_out({{(SAT_IN_W-ACC_W){r_acc[ACC_W-1]}}, r_acc}));
`else
    assign res_out = r_acc[OUT_W-1:0];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next = (len == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_last) begin
                    w_next = ST_DRAIN;
                end
            end
            ST_DRAIN: w_next = ST_DONE;
            ST_DONE: begin
                if (res_ready) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Two-stage datapath: registered product, then accumulate whenever p_v is set.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_len <= '0;
            r_cnt <= '0;
            r_pq  <= '0;
            r_pv  <= 1'b0;
            r_acc <= '0;
        end else if (r_state == ST_IDLE && start) begin
            r_len <= len;
            r_cnt <= '0;
            r_pv  <= 1'b0;
            r_acc <= '0;
        end else begin
            r_pv <= w_xfer;
            if (w_xfer) begin
                r_pq  <= w_prod;
                r_cnt <= w_cnt_inc;
            end
            if (r_pv) begin
                r_acc <= r_acc + {{(ACC_W-PROD_W){r_pq[PROD_W-1]}}, r_pq};
            end
        end
    end

endmodule

// File: tb/tb_mac_seq.sv
// Directed bench for mac_seq: table of dot-product runs plus hand-written
// sequences for start-in-DONE and reset-in-RUN.
module tb_mac_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  len;
    logic        busy;
    logic [7:0]  a_in;
    logic [7:0]  b_in;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] res_out;
    logic        res_valid;
    logic        res_ready;
    logic [1:0]  dbg_state;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mac_seq dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .busy      (busy),
        .a_in      (a_in),
        .b_in      (b_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .res_out   (res_out),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .dbg_state (dbg_state)
    );

    typedef struct {
        int              n;
        logic [3:0][7:0] a;
        logic [3:0][7:0] b;
        int              gap;
        int              rdy_wait;
        logic [15:0]     exp;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int n, input int a0, input int b0, input int a1, input int b1,
                                input int a2, input int b2, input int a3, input int b3,
                                input int gap, input int rdy_wait, input logic [15:0] exp);
        vec_t v;
        v.n = n;
        v.a[0] = a0[7:0]; v.b[0] = b0[7:0];
        v.a[1] = a1[7:0]; v.b[1] = b1[7:0];
        v.a[2] = a2[7:0]; v.b[2] = b2[7:0];
        v.a[3] = a3[7:0]; v.b[3] = b3[7:0];
        v.gap = gap;
        v.rdy_wait = rdy_wait;
        v.exp = exp;
        return v;
    endfunction

    task automatic run_vec(input vec_t v, input string tag);
        @(negedge clk);
        start = 1'b1;
        len   = v.n[7:0];
        @(negedge clk);
        start = 1'b0;
        len   = '0;
        chk({tag, " busy_after_start"}, 32'(busy), 32'd1);
        chk({tag, " in_ready_after_start"}, 32'(in_ready), 32'(v.n != 0));
        if (v.n == 0) begin
            chk({tag, " len0_res_valid"}, 32'(res_valid), 32'd1);
        end else begin
            for (int i = 0; i < v.n; i++) begin
                if (i > 0) begin
                    for (int g = 0; g < v.gap; g++) begin
                        in_valid = 1'b0;
                        @(negedge clk);
                        chk({tag, " gap_res_valid"}, 32'(res_valid), 32'd0);
                    end
                end
                a_in     = v.a[i];
                b_in     = v.b[i];
                in_valid = 1'b1;
                chk({tag, " in_ready_pair"}, 32'(in_ready), 32'd1);
                @(negedge clk);
            end
            in_valid = 1'b0;
            chk({tag, " drain_res_valid"}, 32'(res_valid), 32'd0);
            chk({tag, " drain_in_ready"}, 32'(in_ready), 32'd0);
            chk({tag, " drain_state"}, 32'(dbg_state), 32'd2);
            @(negedge clk);
            chk({tag, " res_valid_k1"}, 32'(res_valid), 32'd1);
        end
        chk({tag, " res_out"}, 32'(res_out), 32'(v.exp));
        chk({tag, " done_in_ready"}, 32'(in_ready), 32'd0);
        for (int w = 0; w < v.rdy_wait; w++) begin
            @(negedge clk);
            chk({tag, " hold_res_valid"}, 32'(res_valid), 32'd1);
            chk({tag, " hold_res_out"}, 32'(res_out), 32'(v.exp));
            chk({tag, " hold_in_ready"}, 32'(in_ready), 32'd0);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk({tag, " res_valid_after_hs"}, 32'(res_valid), 32'd0);
        chk({tag, " busy_after_hs"}, 32'(busy), 32'd0);
    endtask

    vec_t vecs[6];

    initial begin
`ifdef MAC_SAT_EN
        vecs[2] = mk(4, 127, 127, 127, 127, 127, 127, 127, 127, 0, 0, 16'h7FFF);
        vecs[3] = mk(3, -128, 127, -128, 127, -128, 127, 0, 0, 0, 1, 16'h8000);
`else
        vecs[2] = mk(4, 127, 127, 127, 127, 127, 127, 127, 127, 0, 0, 16'hFC04);
        vecs[3] = mk(3, -128, 127, -128, 127, -128, 127, 0, 0, 0, 1, 16'h4180);
`endif
        vecs[0] = mk(4, 60, -20, -16, 32, -16, -96, 112, -32, 0, 0, 16'hF150);
        vecs[1] = mk(4, 60, -20, -16, 32, -16, -96, 112, -32, 2, 3, 16'hF150);
        vecs[4] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000);
        vecs[5] = mk(1, 3, -5, 0, 0, 0, 0, 0, 0, 0, 0, 16'hFFF1);

        rst = 1'b1; start = 1'b0; len = '0; a_in = '0; b_in = '0;
        in_valid = 1'b0; res_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset in_ready", 32'(in_ready), 32'd0);
        chk("reset res_valid", 32'(res_valid), 32'd0);
        chk("reset res_out", 32'(res_out), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // start pulse while in DONE must not relaunch
        @(negedge clk);
        start = 1'b1; len = 8'd0;
        @(negedge clk);
        chk("done_start res_valid", 32'(res_valid), 32'd1);
        len = 8'd5;
        @(negedge clk);
        start = 1'b0; len = '0;
        chk("done_start state", 32'(dbg_state), 32'd3);
        chk("done_start in_ready", 32'(in_ready), 32'd0);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk("done_start back_idle", 32'(dbg_state), 32'd0);
        @(negedge clk);
        chk("done_start stays_idle", 32'(busy), 32'd0);

        // reset in RUN after two of four pairs
        start = 1'b1; len = 8'd4;
        @(negedge clk);
        start = 1'b0; len = '0;
        a_in = 8'd60; b_in = 8'hEC; in_valid = 1'b1;
        @(negedge clk);
        a_in = 8'hF0; b_in = 8'd32;
        @(negedge clk);
        in_valid = 1'b0;
        chk("midrun busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst busy", 32'(busy), 32'd0);
        chk("midrst in_ready", 32'(in_ready), 32'd0);
        chk("midrst res_valid", 32'(res_valid), 32'd0);
        chk("midrst res_out", 32'(res_out), 32'd0);
        run_vec(vecs[5], "after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
